// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_arb_pkg
// Desc     : Shared types and constants for the frame-buffer write arbiter:
//            state encodings, requester indices and round-robin helpers.
// Revision : 1.0 - initial release
// ============================================================================
package fb_arb_pkg;

  localparam int NUM_REQ    = 3;
  localparam int REQ_ALIEN  = 0;
  localparam int REQ_SHIP   = 1;
  localparam int REQ_BULLET = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Modulo-3 add used to walk the round-robin search order.
  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'(NUM_REQ)) begin
      sum = sum - 3'(NUM_REQ);
    end
    return sum[1:0];
  endfunction

  // One-hot grant to requester index (all-zero maps to 0).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[REQ_SHIP]) begin
      idx = 2'd1;
    end else if (oh[REQ_BULLET]) begin
      idx = 2'd2;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter_if
// Desc     : Request/ack bus from the renderers and clear control, plus the
//            RAM port-A write bus driven by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_write_arbiter_if
  import fb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 2
);

  logic [NUM_REQ-1:0]    req;
  logic [ADDR_WIDTH-1:0] req_addr0;
  logic [ADDR_WIDTH-1:0] req_addr1;
  logic [ADDR_WIDTH-1:0] req_addr2;
  logic [DATA_WIDTH-1:0] req_data0;
  logic [DATA_WIDTH-1:0] req_data1;
  logic [DATA_WIDTH-1:0] req_data2;
  logic [NUM_REQ-1:0]    ack;
  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

  // Renderer / controller side.
  modport master (
    output req, req_addr0, req_addr1, req_addr2,
    output req_data0, req_data1, req_data2, clr_start,
    input  ack, clr_busy, clr_done, ram_we, ram_addr, ram_din
  );

  // Arbiter side.
  modport slave (
    input  req, req_addr0, req_addr1, req_addr2,
    input  req_data0, req_data1, req_data2, clr_start,
    output ack, clr_busy, clr_done, ram_we, ram_addr, ram_din
  );

endinterface
`default_nettype wire

// File: rtl/fb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_rr_arbiter
// Desc     : Combinational 3-way round-robin pick. Search starts at ptr and
//            walks ptr, ptr+1, ptr+2 (mod 3); first eligible wins.
// Revision : 1.0 - initial release
// ============================================================================
module fb_rr_arbiter
  import fb_arb_pkg::*;
(
  input  wire [NUM_REQ-1:0] eligible,
  input  wire [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [1:0] idx;

  // First eligible requester in rotated priority order.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = wrap_idx(ptr, i[1:0]);
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter
// Desc     : Owns frame-buffer write port A. Round-robin arbitration between
//            alien/ship/bullet renderers plus an optional full-buffer clear
//            engine (enabled by defining FB_ARB_CLEAR_EN). All RAM-side
//            outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 22,
  parameter int                    DATA_WIDTH  = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input wire                clk,
  input wire                reset_n,
  fb_write_arbiter_if.slave bus
);

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

`ifdef FB_ARB_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clr_busy_q, clr_busy_d;
  logic                  clr_done_q, clr_done_d;
`else
  wire unused_clr_start = bus.clr_start;
`endif

  // A requester acked this cycle is still holding req; mask it to avoid a repeat write.
  assign eligible = bus.req & ~ack_q;

  fb_rr_arbiter u_rr (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .valid    (grant_valid)
  );

  // Route the winning requester's address and data toward the write port.
  always_comb begin
    sel_addr = bus.req_addr2;
    sel_data = bus.req_data2;
    if (grant[REQ_ALIEN]) begin
      sel_addr = bus.req_addr0;
      sel_data = bus.req_data0;
    end else if (grant[REQ_SHIP]) begin
      sel_addr = bus.req_addr1;
      sel_data = bus.req_data1;
    end
  end

  // Next-state, next-pointer and next registered-output computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ack_d      = '0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
`ifdef FB_ARB_CLEAR_EN
    clr_addr_d = clr_addr_q;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_SERVE: begin
`ifdef FB_ARB_CLEAR_EN
        // Clear beats any pending request; the write already on the port finishes.
        if (bus.clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          clr_busy_d = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_din_d  = CLEAR_VALUE;
        end else
`endif
        if (grant_valid) begin
          state_d    = ST_SERVE;
          ack_d      = grant;
          ram_we_d   = 1'b1;
          ram_addr_d = sel_addr;
          ram_din_d  = sel_data;
          ptr_d      = wrap_idx(onehot_to_idx(grant), 2'd1);
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef FB_ARB_CLEAR_EN
      ST_CLEAR: begin
        // Sweep ends at all-ones; clr_start is not looked at here.
        if (clr_addr_q == ADDR_LAST) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_ONE;
          clr_busy_d = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = clr_addr_q + ADDR_ONE;
          ram_din_d  = CLEAR_VALUE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any serve or clear at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      ack_q      <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
`ifdef FB_ARB_CLEAR_EN
      clr_addr_q <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
`ifdef FB_ARB_CLEAR_EN
      clr_addr_q <= clr_addr_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
`ifdef FB_ARB_CLEAR_EN
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
`else
  assign bus.clr_busy = 1'b0;
  assign bus.clr_done = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_arbiter
// Desc     : Directed self-checking bench for fb_write_arbiter, ADDR_WIDTH=4.
//            Clear-engine steps follow FB_ARB_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

  localparam int         AW = 4;
  localparam int         DW = 2;
  localparam logic [1:0] CV = 2'd3;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  fb_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fb_write_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .CLEAR_VALUE (CV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0] exp_ack;
    total = 0;
    bad   = 0;
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;
    bus.req_addr2 = '0;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.req_data2 = '0;
    bus.clr_start = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_we",    32'(bus.ram_we),   0);
    check("rst_addr",  32'(bus.ram_addr), 0);
    check("rst_din",   32'(bus.ram_din),  0);
    check("rst_ack",   32'(bus.ack),      0);
    check("rst_busy",  32'(bus.clr_busy), 0);
    check("rst_done",  32'(bus.clr_done), 0);
    check("rst_state", 32'(dut.state_q),  0);
    reset_n = 1'b1;
    tick();
    check("idle_we", 32'(bus.ram_we), 0);

    // Single requester, held one cycle past ack
    bus.req       = 3'b001;
    bus.req_addr0 = 4'd5;
    bus.req_data0 = 2'd2;
    tick();
    check("s_we",   32'(bus.ram_we),   1);
    check("s_addr", 32'(bus.ram_addr), 5);
    check("s_din",  32'(bus.ram_din),  2);
    check("s_ack",  32'(bus.ack),      32'b001);
    tick();
    check("s_mask_ack", 32'(bus.ack),    0);
    check("s_mask_we",  32'(bus.ram_we), 0);
    bus.req = '0;
    tick();
    check("s_after_ack", 32'(bus.ack), 0);

    // Round robin from a fresh pointer, all three requesting
    do_reset();
    bus.req       = 3'b111;
    bus.req_addr0 = 4'd1;
    bus.req_addr1 = 4'd2;
    bus.req_addr2 = 4'd3;
    bus.req_data0 = 2'd1;
    bus.req_data1 = 2'd2;
    bus.req_data2 = 2'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_ack = 3'b001 << (i % 3);
      check("rr_ack",  32'(bus.ack),      32'(exp_ack));
      check("rr_we",   32'(bus.ram_we),   1);
      check("rr_addr", 32'(bus.ram_addr), 32'((i % 3) + 1));
      check("rr_din",  32'(bus.ram_din),  32'((i % 3) + 1));
    end
    bus.req = '0;
    tick();
    check("rr_end_we",  32'(bus.ram_we), 0);
    check("rr_end_ack", 32'(bus.ack),    0);

`ifdef FB_ARB_CLEAR_EN
    // Full clear with an ignored second start at address 7
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("c_busy0", 32'(bus.clr_busy), 1);
    check("c_we0",   32'(bus.ram_we),   1);
    check("c_addr0", 32'(bus.ram_addr), 0);
    check("c_din0",  32'(bus.ram_din),  32'(CV));
    check("c_done0", 32'(bus.clr_done), 0);
    for (int a = 1; a < 16; a++) begin
      tick();
      check("c_addr", 32'(bus.ram_addr), 32'(a));
      check("c_busy", 32'(bus.clr_busy), 1);
      check("c_we",   32'(bus.ram_we),   1);
      check("c_din",  32'(bus.ram_din),  32'(CV));
      bus.clr_start = (a == 7);
    end
    tick();
    check("c_done", 32'(bus.clr_done), 1);
    check("c_idle", 32'(bus.clr_busy), 0);
    check("c_dwe",  32'(bus.ram_we),   0);
    tick();
    check("c_done_pulse", 32'(bus.clr_done), 0);

    // Request during clear waits until after clr_done
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    bus.req       = 3'b010;
    bus.req_addr1 = 4'd9;
    bus.req_data1 = 2'd1;
    for (int a = 1; a < 16; a++) begin
      tick();
      check("cw_noack", 32'(bus.ack), 0);
    end
    tick();
    check("cw_done",  32'(bus.clr_done), 1);
    check("cw_ack0",  32'(bus.ack),      0);
    tick();
    check("cw_ack",   32'(bus.ack),      32'b010);
    check("cw_addr",  32'(bus.ram_addr), 9);
    check("cw_din",   32'(bus.ram_din),  1);
    bus.req = '0;
    tick();

    // Reset mid-clear, then restart from address 0
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    repeat (9) tick();
    check("ca_addr9", 32'(bus.ram_addr), 9);
    reset_n = 1'b0;
    #2;
    check("ca_we",   32'(bus.ram_we),   0);
    check("ca_addr", 32'(bus.ram_addr), 0);
    check("ca_busy", 32'(bus.clr_busy), 0);
    check("ca_din",  32'(bus.ram_din),  0);
    reset_n = 1'b1;
    tick();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("cr_addr", 32'(bus.ram_addr), 0);
    check("cr_busy", 32'(bus.clr_busy), 1);
    repeat (15) tick();
    check("cr_last", 32'(bus.ram_addr), 15);
    tick();
    check("cr_done", 32'(bus.clr_done), 1);
`else
    // Clear engine absent: clr_start is ignored and requests proceed
    bus.clr_start = 1'b1;
    bus.req       = 3'b010;
    bus.req_addr1 = 4'd9;
    bus.req_data1 = 2'd1;
    tick();
    bus.clr_start = 1'b0;
    check("nc_busy", 32'(bus.clr_busy), 0);
    check("nc_ack",  32'(bus.ack),      32'b010);
    check("nc_addr", 32'(bus.ram_addr), 9);
    bus.req = '0;
    tick();
    check("nc_done", 32'(bus.clr_done), 0);
    check("nc_we",   32'(bus.ram_we),   0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

- Arbitrates the single write port of the video frame buffer (`dual_port_ram`, port A) between three game renderers: alien, ship and bullet.
- Contains a built-in clear engine that sweeps the whole buffer to a background value.
- Drives `we`, `addr_a` and `din_a` of the RAM from registered outputs.
- Read port B stays owned by the VGA scan logic and is not touched by this block.

## Interface
Parameters:
- `ADDR_WIDTH`, 22, frame-buffer address width; must match the RAM.
- `DATA_WIDTH`, 2, pixel width; must match the RAM.
- `CLEAR_VALUE`, 0, pixel value written by the clear engine.

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req[2:0]` in 3: write request per requester. 0 = alien, 1 = ship, 2 = bullet.
- `req_addr0..2` in ADDR_WIDTH each: write address per requester.
- `req_data0..2` in DATA_WIDTH each: write data per requester.
- `ack[2:0]` out 3: one-cycle pulse, high in the cycle the requester's write is on the RAM port.
- `clr_start` in 1: single-cycle pulse that starts a full-buffer clear.
- `clr_busy` out 1: high while the clear sweep runs.
- `clr_done` out 1: one-cycle pulse after the last clear write.
- `ram_we` out 1: connects to RAM `we`.
- `ram_addr` out ADDR_WIDTH: connects to RAM `addr_a`.
- `ram_din` out DATA_WIDTH: connects to RAM `din_a`.

## Operation
- States: IDLE, SERVE, CLEAR.
- IDLE:
  - `clr_start` → CLEAR. This has priority over any `req`.
  - Otherwise, any eligible `req` → SERVE.
- SERVE:
  - Issues one write per cycle while eligible requests exist.
  - Returns to IDLE when no eligible request remains.
  - `clr_start` → CLEAR. The write already registered this cycle completes; no further grants are made.
- CLEAR:
  - `clr_addr` counts 0 to 2^ADDR_WIDTH−1, one write per cycle, data = CLEAR_VALUE.
  - After the final address → IDLE with `clr_done` pulse.
  - `clr_start` during CLEAR is ignored; the sweep does not restart.
- Arbitration is round-robin among eligible requesters:
  - Pointer starts at requester 0 after reset.
  - After a grant to requester k, search order is k+1, k+2, k.
- Eligibility: `req[i]` is high and requester i was not acked in the current cycle. This mask prevents a double write while the requester deasserts after its ack.
- Requester contract:
  - Hold `req`, address and data stable until `ack`.
  - Deassert, or present new data, on the cycle after `ack`.
- During CLEAR no `ack` is issued. Pending requests wait and are served after `clr_done`, in round-robin order.
- The clear address counter uses exactly ADDR_WIDTH bits. Termination is detected at all-ones; the counter does not wrap.

## Timing
- Reset values: all outputs 0. State IDLE, RR pointer selects requester 0 first, `clr_addr` 0.
- Reset assertion mid-CLEAR or mid-SERVE aborts immediately. No partial-clear indication is given.
- Grant latency: `req` high at edge N → `ram_we`, `ram_addr`, `ram_din` and `ack` all high/valid after edge N+1.
- Single-requester throughput: one write every 2 cycles, because of the ack mask. With ≥2 requesters the port is busy every cycle.
- Clear:
  - `clr_start` sampled at edge N → `clr_busy` high and first clear write (addr 0) after edge N+1.
  - Last write (addr 2^ADDR_WIDTH−1) is at cycle N+2^ADDR_WIDTH.
  - In the cycle after the last write: `clr_done` = 1 and `clr_busy` = 0.
- `clr_start` and `req` at the same edge: the clear wins and the request is deferred.

## Configuration
- `FB_ARB_CLEAR_EN`:
  - Defined: the clear engine, CLEAR state and counter are present.
  - Undefined: `clr_start` is ignored, `clr_busy` and `clr_done` are tied 0, and the state machine has only IDLE and SERVE.

## Structure
- Shared package/include `fb_arb_pkg` contains:
  - State encodings: IDLE = 2'd0, SERVE = 2'd1, CLEAR = 2'd2.
  - `NUM_REQ` = 3.
  - Requester index constants: `REQ_ALIEN`, `REQ_SHIP`, `REQ_BULLET`.
- One sub-module, `fb_rr_arbiter`:
  - Inputs: 3-bit eligible vector and pointer.
  - Outputs: one-hot grant and valid.
  - Combinational; the pointer register stays in the top level.

## Test plan
Bench uses ADDR_WIDTH = 4.
- Reset → all outputs 0, state IDLE.
- `req` = 3'b001, addr 5, data 2 → `ram_we` = 1, `ram_addr` = 5, `ram_din` = 2, `ack` = 3'b001 one cycle later. Holding `req` one extra cycle produces no second `ack` in the next cycle.
- `req` = 3'b111 held continuously → ack order 0, 1, 2, 0, 1, 2, with `ram_we` high every cycle.
- `clr_start` pulse → `clr_busy` for 16 cycles, addresses 0..15 with `ram_din` = CLEAR_VALUE, then `clr_done` one cycle. A second `clr_start` at address 7 has no effect.
- `req[1]` raised during a clear → no ack until `clr_done`, then `ack[1]` in the next cycle.
- `reset_n` low at clear address 9 → outputs 0 immediately. A following `clr_start` restarts at address 0.
